// File: rtl/cube_pkg.sv
// Shared types and constants for the cube line rasteriser.
package cube_pkg;

   // Frame walk: fetch a table entry, set up the stepper, draw, advance.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      DRAW,
      NEXT,
      DONE
   } state_t;

   // A cube has 12 edges.
   localparam int NUM_LINES_DEF = 12;

   // Extra bits on top of the coordinate width for the signed Bresenham terms.
   // One bit is for the sign and one is so |x1-x0| + |y1-y0| cannot overflow.
   localparam int STEP_HEADROOM = 2;

endpackage

// File: rtl/cube_line_raster_if.sv
// Line-table and pixel-write bus between the rasteriser and its surroundings.
interface cube_line_raster_if #(
   parameter int XY_BITW = 16,
   parameter int LINEW   = 4,
   parameter int COLORW  = 3
) ();

   // Line table: the index goes out, and the endpoints come back combinationally.
   logic [LINEW-1:0]   line_id;
   logic [XY_BITW-1:0] seg_x0;
   logic [XY_BITW-1:0] seg_y0;
   logic [XY_BITW-1:0] seg_x1;
   logic [XY_BITW-1:0] seg_y1;
   logic [COLORW-1:0]  seg_color;

   // Pixel write port with a valid/ready handshake.
   logic               pix_valid;
   logic               pix_ready;
   logic [XY_BITW-1:0] pix_x;
   logic [XY_BITW-1:0] pix_y;
   logic [COLORW-1:0]  pix_color;

   modport master (
      output line_id,
      input  seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
      output pix_valid, pix_x, pix_y, pix_color,
      input  pix_ready
   );

   modport slave (
      input  line_id,
      output seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
      input  pix_valid, pix_x, pix_y, pix_color,
      output pix_ready
   );

endinterface

// File: rtl/line_stepper.sv
// Bresenham datapath for one line: initialise from the endpoints, step one
// pixel per accepted write, and flag when the current pixel is the far end.
module line_stepper
   import cube_pkg::*;
#(
   parameter int XY_BITW = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               step,
   input  logic [XY_BITW-1:0] x0,
   input  logic [XY_BITW-1:0] y0,
   input  logic [XY_BITW-1:0] x1,
   input  logic [XY_BITW-1:0] y1,
   output logic [XY_BITW-1:0] cur_x,
   output logic [XY_BITW-1:0] cur_y,
   output logic               at_end
);

   localparam int SW = XY_BITW + STEP_HEADROOM;
   // 2*err needs one more bit than err itself.
   localparam int EW = SW + 1;
   localparam logic [XY_BITW-1:0] ONE = XY_BITW'(1);

   typedef logic signed [SW-1:0] sw_t;

   sw_t               dx, dy, err;
   logic              sx_neg, sy_neg;
   sw_t               x0s, y0s, x1s, y1s;
   sw_t               adx, ady, err_n;
   logic signed [EW-1:0] e2;
   logic              x_go, y_go;

   // Setup terms from the unsigned endpoints, and the next Bresenham step.
   always_comb begin
      x0s   = $signed({{STEP_HEADROOM{1'b0}}, x0});
      y0s   = $signed({{STEP_HEADROOM{1'b0}}, y0});
      x1s   = $signed({{STEP_HEADROOM{1'b0}}, x1});
      y1s   = $signed({{STEP_HEADROOM{1'b0}}, y1});
      adx   = (x1s >= x0s) ? (x1s - x0s) : (x0s - x1s);
      ady   = (y1s >= y0s) ? (y1s - y0s) : (y0s - y1s);
      e2    = $signed({err, 1'b0});
      // Both decisions use the same e2, so a diagonal step moves x and y
      // together.
      x_go  = (e2 >= EW'(dy));
      y_go  = (e2 <= EW'(dx));
      err_n = err;
      if (x_go) err_n = err_n + dy;
      if (y_go) err_n = err_n + dx;
   end

   // Stepper registers: load on init, and advance one pixel on step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
         cur_x  <= '0;
         cur_y  <= '0;
      end else if (init) begin
         dx     <= adx;
         dy     <= -ady;
         err    <= adx - ady;
         sx_neg <= !(x0 < x1);
         sy_neg <= !(y0 < y1);
         cur_x  <= x0;
         cur_y  <= y0;
      end else if (step) begin
         err <= err_n;
         if (x_go) cur_x <= sx_neg ? (cur_x - ONE) : (cur_x + ONE);
         if (y_go) cur_y <= sy_neg ? (cur_y - ONE) : (cur_y + ONE);
      end
   end

   // Endpoints are inclusive, so the far end is itself a pixel to emit.
   assign at_end = (cur_x == x1) && (cur_y == y1);

endmodule

// File: rtl/cube_line_raster.sv
// Walks a line table (external, addressed by line_id) and rasterises each
// entry through a Bresenham stepper onto a valid/ready pixel port.
module cube_line_raster
   import cube_pkg::*;
#(
   parameter int XY_BITW   = 16,
   parameter int LINEW     = 4,
   parameter int COLORW    = 3,
   parameter int NUM_LINES = NUM_LINES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [XY_BITW-1:0] org_x,
   input  logic [XY_BITW-1:0] org_y,
   cube_line_raster_if.master bus,
   output logic               busy,
   output logic               done
);

   state_t             state, state_nxt;
   logic [LINEW-1:0]   line_id_q;
   logic [XY_BITW-1:0] x0_q, y0_q, x1_q, y1_q;
   logic [COLORW-1:0]  color_q;
   logic [XY_BITW-1:0] cur_x, cur_y;
   logic               at_end;
   logic               in_draw, hs, last_line;

   assign in_draw   = (state == DRAW);
   assign hs        = in_draw && bus.pix_ready;
   assign last_line = (line_id_q == LINEW'(NUM_LINES - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and status outputs. start only counts in IDLE.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: begin
            busy      = 1'b1;
            state_nxt = SETUP;
         end
         SETUP: begin
            busy      = 1'b1;
            state_nxt = DRAW;
         end
         DRAW: begin
            busy = 1'b1;
            if (hs && at_end) state_nxt = NEXT;
         end
         NEXT: begin
            busy      = 1'b1;
            state_nxt = last_line ? DONE : FETCH;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line index and latched table entry. The table answers for the line_id
   // that is already held, so FETCH only has to capture its outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_id_q <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         color_q   <= '0;
      end else begin
         if (state == IDLE && start)
            line_id_q <= '0;
         else if (state == NEXT && !last_line)
            line_id_q <= line_id_q + LINEW'(1);
         if (state == FETCH) begin
            x0_q    <= bus.seg_x0;
            y0_q    <= bus.seg_y0;
            x1_q    <= bus.seg_x1;
            y1_q    <= bus.seg_y1;
            color_q <= bus.seg_color;
         end
      end
   end

   line_stepper #(
      .XY_BITW (XY_BITW)
   ) u_step (
      .clk    (clk),
      .rst    (rst),
      .init   (state == SETUP),
      .step   (hs && !at_end),
      .x0     (x0_q),
      .y0     (y0_q),
      .x1     (x1_q),
      .y1     (y1_q),
      .cur_x  (cur_x),
      .cur_y  (cur_y),
      .at_end (at_end)
   );

   // The pixel port is decoded from registered state. While a write is
   // stalled, nothing below changes, so the write holds steady. Outside DRAW
   // the port is zeroed, so a reset or an idle state leaves no residue from
   // org_x or org_y.
   assign bus.line_id   = line_id_q;
   assign bus.pix_valid = in_draw;
   assign bus.pix_x     = in_draw ? (cur_x + org_x) : '0;
   assign bus.pix_y     = in_draw ? (cur_y + org_y) : '0;
   assign bus.pix_color = in_draw ? color_q : '0;

endmodule

// File: tb/tb_cube_line_raster.sv
// Directed bench: a 10x10x5 cube table on the main instance, and a one-line
// stub table on a second instance with NUM_LINES=1.
module tb_cube_line_raster;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [2:0]  c;
   } pix_t;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, start1 = 1'b0, rdy = 1'b1;
   logic [15:0] org_x = 16'd0, org_y = 16'd0;
   logic        busy, done, busy1, done1;
   logic [15:0] s_x0 = 16'd3, s_y0 = 16'd7, s_x1 = 16'd3, s_y1 = 16'd7;

   int n_vec = 0, n_bad = 0;
   int done_cnt = 0, done1_cnt = 0, stall_seen = 0, stall_err = 0, proto_err = 0;
   pix_t got_q[$], got1_q[$], exp_q[$];
   bit   prev_stall = 0;
   pix_t prev_pix;

   // Cube edges: front face, back face offset by (5,5), then the depth edges.
   int tx0[12] = '{0, 0,10,10, 5, 5,15,15, 0, 0,10,10};
   int ty0[12] = '{0,10,10, 0, 5,15,15, 5, 0,10,10, 0};
   int tx1[12] = '{0,10,10, 0, 5,15,15, 5, 5, 5,15,15};
   int ty1[12] = '{10,10,0, 0,15,15, 5, 5, 5,15,15, 5};

   cube_line_raster_if #(.XY_BITW(16), .LINEW(4), .COLORW(3)) bus  ();
   cube_line_raster_if #(.XY_BITW(16), .LINEW(4), .COLORW(3)) bus1 ();

   always #5 clk = ~clk;

   assign bus.pix_ready  = rdy;
   assign bus1.pix_ready = 1'b1;
   assign bus1.seg_x0    = s_x0;
   assign bus1.seg_y0    = s_y0;
   assign bus1.seg_x1    = s_x1;
   assign bus1.seg_y1    = s_y1;
   assign bus1.seg_color = 3'd5;

   // Combinational cube table; line l has colour (l+1) mod 8.
   always_comb begin
      bus.seg_x0    = '0;
      bus.seg_y0    = '0;
      bus.seg_x1    = '0;
      bus.seg_y1    = '0;
      bus.seg_color = '0;
      if (bus.line_id < 4'd12) begin
         bus.seg_x0    = 16'(tx0[bus.line_id]);
         bus.seg_y0    = 16'(ty0[bus.line_id]);
         bus.seg_x1    = 16'(tx1[bus.line_id]);
         bus.seg_y1    = 16'(ty1[bus.line_id]);
         bus.seg_color = 3'(bus.line_id + 4'd1);
      end
   end

   cube_line_raster #(.XY_BITW(16), .LINEW(4), .COLORW(3), .NUM_LINES(12)) u_dut (
      .clk(clk), .rst(rst), .start(start), .org_x(org_x), .org_y(org_y),
      .bus(bus), .busy(busy), .done(done));

   cube_line_raster #(.XY_BITW(16), .LINEW(4), .COLORW(3), .NUM_LINES(1)) u_stub (
      .clk(clk), .rst(rst), .start(start1), .org_x(16'd0), .org_y(16'd0),
      .bus(bus1), .busy(busy1), .done(done1));

   // Monitor at negedge: record accepted pixels, done pulses, and whether a
   // stalled write stayed put.
   always @(negedge clk) begin
      if (bus.pix_valid && rdy) got_q.push_back('{bus.pix_x, bus.pix_y, bus.pix_color});
      if (bus1.pix_valid) got1_q.push_back('{bus1.pix_x, bus1.pix_y, bus1.pix_color});
      if (done)  done_cnt++;
      if (done1) done1_cnt++;
      if (bus.pix_valid && !busy) proto_err++;
      if (prev_stall && rst) begin
         stall_seen++;
         if (!bus.pix_valid || prev_pix !== pix_t'{bus.pix_x, bus.pix_y, bus.pix_color})
            stall_err++;
      end
      prev_stall = bus.pix_valid && !rdy && rst;
      prev_pix   = '{bus.pix_x, bus.pix_y, bus.pix_color};
   end

   task automatic build_exp(input int ox, input int oy);
      exp_q.delete();
      for (int l = 0; l < 12; l++) begin
         int ddx = tx1[l] - tx0[l];
         int ddy = ty1[l] - ty0[l];
         int ax  = (ddx < 0) ? -ddx : ddx;
         int ay  = (ddy < 0) ? -ddy : ddy;
         int n   = ((ax > ay) ? ax : ay) + 1;
         int stx = (ddx > 0) ? 1 : (ddx < 0) ? -1 : 0;
         int sty = (ddy > 0) ? 1 : (ddy < 0) ? -1 : 0;
         for (int k = 0; k < n; k++)
            exp_q.push_back('{16'(tx0[l] + k*stx + ox), 16'(ty0[l] + k*sty + oy), 3'((l + 1) % 8)});
      end
   endtask

   function automatic int first_diff();
      int lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++) if (got_q[i] !== exp_q[i]) return i;
      return (got_q.size() == exp_q.size()) ? -1 : lim;
   endfunction

   task automatic run_frame(input bit rand_rdy, input bit mid_start,
                            output bit ok, output logic bsy, output int cyc);
      int d0 = done_cnt;
      bit poked = 0;
      ok = 0; cyc = 0;
      got_q.delete();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0; bsy = busy;
      for (int c = 1; c <= 4000; c++) begin
         if (rand_rdy) rdy = 1'($urandom_range(0, 1));
         if (mid_start && !poked && got_q.size() >= 50) begin start = 1; poked = 1; end
         else start = 0;
         @(posedge clk); #1;
         if (done_cnt != d0) begin ok = 1; cyc = c; break; end
      end
      start = 0; rdy = 1;
   endtask

   task automatic run_stub(output bit ok);
      int d1 = done1_cnt;
      ok = 0;
      got1_q.delete();
      @(posedge clk); #1 start1 = 1;
      @(posedge clk); #1 start1 = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done1_cnt != d1) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset;
      org_x = 16'd100; org_y = 16'd50;
      repeat (2) @(negedge clk); #1;
      n_vec++; if (bus.pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.pix_valid); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (bus.line_id !== 4'd0) begin n_bad++; $display("FAIL reset_line_id got %0d want 0", bus.line_id); end
      n_vec++; if (bus.pix_x !== 16'd0 || bus.pix_y !== 16'd0) begin n_bad++; $display("FAIL reset_pix_xy got %0d,%0d want 0,0", bus.pix_x, bus.pix_y); end
      n_vec++; if (bus.pix_color !== 3'd0) begin n_bad++; $display("FAIL reset_color got %0d want 0", bus.pix_color); end
      @(posedge clk); #1 rst = 1; org_x = 16'd0; org_y = 16'd0;
   endtask

   task automatic test_cube;
      bit ok; logic bsy; int cyc, d0, fd;
      d0 = done_cnt;
      build_exp(0, 0);
      run_frame(0, 0, ok, bsy, cyc);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL cube_timeout done not seen got 0 want 1"); end
      n_vec++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL cube_busy_start got %b want 1", bsy); end
      n_vec++; if (cyc != 149) begin n_bad++; $display("FAIL cube_cycles got %0d want 149", cyc); end
      n_vec++; if (got_q.size() != 112) begin n_bad++; $display("FAIL cube_count got %0d want 112", got_q.size()); end
      for (int k = 0; k < 11; k++) begin
         n_vec++;
         if (got_q[k] !== pix_t'{16'd0, 16'(k), 3'd1}) begin
            n_bad++; $display("FAIL line0_px%0d got (%0d,%0d,c%0d) want (0,%0d,c1)", k, got_q[k].x, got_q[k].y, got_q[k].c, k);
         end
      end
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (got_q[88+k] !== pix_t'{16'(k), 16'(k), 3'd1}) begin
            n_bad++; $display("FAIL line8_px%0d got (%0d,%0d,c%0d) want (%0d,%0d,c1)", k, got_q[88+k].x, got_q[88+k].y, got_q[88+k].c, k, k);
         end
      end
      fd = first_diff();
      n_vec++; if (fd >= 0) begin n_bad++; $display("FAIL cube_seq first diff at idx %0d got %0d pixels want %0d", fd, got_q.size(), exp_q.size()); end
      repeat (5) @(negedge clk); #1;
      n_vec++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL cube_done_pulses got %0d want 1", done_cnt - d0); end
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL cube_idle_after busy %b done %b want 0 0", busy, done); end
      n_vec++; if (proto_err != 0) begin n_bad++; $display("FAIL valid_outside_busy got %0d want 0", proto_err); end
   endtask

   task automatic test_origin;
      bit ok; logic bsy; int cyc, fd;
      org_x = 16'd100; org_y = 16'd50;
      build_exp(100, 50);
      run_frame(0, 0, ok, bsy, cyc);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL origin_timeout done not seen got 0 want 1"); end
      for (int k = 0; k < 11; k++) begin
         n_vec++;
         if (got_q[11+k] !== pix_t'{16'(100+k), 16'd60, 3'b010}) begin
            n_bad++; $display("FAIL origin_line1_px%0d got (%0d,%0d,c%0d) want (%0d,60,c2)", k, got_q[11+k].x, got_q[11+k].y, got_q[11+k].c, 100+k);
         end
      end
      fd = first_diff();
      n_vec++; if (fd >= 0) begin n_bad++; $display("FAIL origin_seq first diff at idx %0d got %0d pixels want %0d", fd, got_q.size(), exp_q.size()); end
      org_x = 16'd0; org_y = 16'd0;
   endtask

   task automatic test_stall;
      bit ok; logic bsy; int cyc, fd, s0, e0;
      s0 = stall_seen; e0 = stall_err;
      build_exp(0, 0);
      run_frame(1, 0, ok, bsy, cyc);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL stall_timeout done not seen got 0 want 1"); end
      fd = first_diff();
      n_vec++; if (fd >= 0) begin n_bad++; $display("FAIL stall_seq first diff at idx %0d got %0d pixels want %0d", fd, got_q.size(), exp_q.size()); end
      n_vec++; if (stall_seen == s0) begin n_bad++; $display("FAIL stall_exercised got 0 stalls want >0"); end
      n_vec++; if (stall_err != e0) begin n_bad++; $display("FAIL stall_stable got %0d changes want 0", stall_err - e0); end
   endtask

   task automatic test_degenerate;
      bit ok; int d1;
      d1 = done1_cnt;
      s_x0 = 16'd3; s_y0 = 16'd7; s_x1 = 16'd3; s_y1 = 16'd7;
      run_stub(ok);
      repeat (3) @(negedge clk); #1;
      n_vec++; if (!ok) begin n_bad++; $display("FAIL degen_timeout done not seen got 0 want 1"); end
      n_vec++; if (got1_q.size() != 1) begin n_bad++; $display("FAIL degen_count got %0d want 1", got1_q.size()); end
      n_vec++; if (got1_q[0] !== pix_t'{16'd3, 16'd7, 3'd5}) begin n_bad++; $display("FAIL degen_pixel got (%0d,%0d,c%0d) want (3,7,c5)", got1_q[0].x, got1_q[0].y, got1_q[0].c); end
      n_vec++; if (done1_cnt - d1 != 1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL degen_done got pulses %0d busy %b want 1 0", done1_cnt - d1, busy1); end
      n_vec++; if (bus1.line_id !== 4'd0) begin n_bad++; $display("FAIL degen_line_id got %0d want 0", bus1.line_id); end
   endtask

   // Shallow line both ways: (0,0)->(4,2) and (4,2)->(0,0).
   task automatic test_slope;
      bit ok;
      int fx[5] = '{0,1,2,3,4};
      int fy[5] = '{0,1,1,2,2};
      int rx[5] = '{4,3,2,1,0};
      int ry[5] = '{2,1,1,0,0};
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin s_x0 = 16'd0; s_y0 = 16'd0; s_x1 = 16'd4; s_y1 = 16'd2; end
         else        begin s_x0 = 16'd4; s_y0 = 16'd2; s_x1 = 16'd0; s_y1 = 16'd0; end
         run_stub(ok);
         n_vec++; if (!ok || got1_q.size() != 5) begin n_bad++; $display("FAIL slope%0d_count got %0d want 5", d, got1_q.size()); end
         for (int k = 0; k < 5; k++) begin
            int wx = (d == 0) ? fx[k] : rx[k];
            int wy = (d == 0) ? fy[k] : ry[k];
            n_vec++;
            if (got1_q[k] !== pix_t'{16'(wx), 16'(wy), 3'd5}) begin
               n_bad++; $display("FAIL slope%0d_px%0d got (%0d,%0d) want (%0d,%0d)", d, k, got1_q[k].x, got1_q[k].y, wx, wy);
            end
         end
      end
   endtask

   task automatic test_reset_mid_draw;
      bit hit = 0; bit fin = 0; int d0;
      got_q.delete(); rdy = 1;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         if (got_q.size() >= 20) begin hit = 1; break; end
      end
      n_vec++; if (!hit) begin n_bad++; $display("FAIL rstmid_timeout 20 pixels not seen got %0d", got_q.size()); end
      #2 rst = 0; #1;
      n_vec++; if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async valid %b busy %b want 0 0", bus.pix_valid, busy); end
      d0 = done_cnt;
      repeat (3) @(negedge clk); #1;
      n_vec++; if (got_q.size() != 20) begin n_bad++; $display("FAIL rstmid_no_more_pixels got %0d want 20", got_q.size()); end
      @(posedge clk); #1 rst = 1; got_q.delete();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      n_vec++; if (bus.line_id !== 4'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart line_id %0d busy %b want 0 1", bus.line_id, busy); end
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         if (done_cnt != d0) begin fin = 1; break; end
      end
      n_vec++; if (got_q[0] !== pix_t'{16'd0, 16'd0, 3'd1}) begin n_bad++; $display("FAIL rstmid_first got (%0d,%0d,c%0d) want (0,0,c1)", got_q[0].x, got_q[0].y, got_q[0].c); end
      n_vec++; if (!fin || got_q.size() != 112) begin n_bad++; $display("FAIL rstmid_refill got %0d pixels want 112", got_q.size()); end
   endtask

   task automatic test_back_to_back;
      bit ok; logic bsy; int cyc, fd, d0;
      d0 = done_cnt;
      build_exp(0, 0);
      run_frame(0, 1, ok, bsy, cyc);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout done not seen got 0 want 1"); end
      fd = first_diff();
      n_vec++; if (fd >= 0) begin n_bad++; $display("FAIL b2b_seq first diff at idx %0d got %0d pixels want %0d", fd, got_q.size(), exp_q.size()); end
      n_vec++; if (cyc != 149) begin n_bad++; $display("FAIL b2b_cycles got %0d want 149", cyc); end
      repeat (20) @(negedge clk); #1;
      n_vec++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_single_done pulses %0d busy %b want 1 0", done_cnt - d0, busy); end
      n_vec++; if (proto_err != 0) begin n_bad++; $display("FAIL b2b_valid_outside_busy got %0d want 0", proto_err); end
   endtask

   initial begin
      test_reset;
      test_cube;
      test_origin;
      test_stall;
      test_degenerate;
      test_slope;
      test_reset_mid_draw;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
